// File: rtl/credit_bp_tx.sv
// Transmit-side credit manager: round-robin picks one credit-eligible VC per cycle
// and drives a registered flit plus one-hot VC target onto the credit link.
module credit_bp_tx #(
  parameter int A_W           = 8,
  parameter int D_W           = 32,
  parameter int VC_W          = 2,
  parameter int VC_FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [VC_W-1:0]                 i_v,
  input  logic [VC_W-1:0][A_W+D_W:0]      i_d,
  output logic [VC_W-1:0]                 o_b,
  output logic [A_W+D_W:0]                o_d,
  output logic [VC_W-1:0]                 o_vc_target,
  input  logic [VC_W-1:0]                 i_credit_gnt
);

  localparam int FW = A_W + D_W + 1;
  localparam int CW = $clog2(VC_FIFO_DEPTH) + 1;
  localparam int PW = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam logic [CW-1:0] MAX_CREDIT = CW'(VC_FIFO_DEPTH - 1);

  logic [VC_W-1:0][CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [FW-1:0]           data_q, data_d;
  logic [VC_W-1:0]         target_q, target_d;
  logic [VC_W-1:0]         elig, gnt, ovf;
  logic [PW-1:0]           selVc;
  logic                    xfer;

  always_comb begin
    for (int v = 0; v < VC_W; v++) begin
      elig[v] = i_v[v] && (cnt_q[v] != '0);
    end
  end

  // Scan from the pointer upward with wrap; the first eligible VC wins.
  always_comb begin
    gnt   = '0;
    selVc = '0;
    xfer  = 1'b0;
    for (int i = 0; i < VC_W; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % VC_W;
      if (!xfer && elig[idx]) begin
        gnt[idx] = 1'b1;
        selVc    = PW'(idx);
        xfer     = 1'b1;
      end
    end
  end

  assign o_b = ~gnt;

  always_comb begin
    ptr_d    = ptr_q;
    data_d   = data_q;
    target_d = '0;
    if (xfer) begin
      data_d   = i_d[selVc];
      target_d = gnt;
      ptr_d    = (int'(selVc) == VC_W - 1) ? '0 : selVc + PW'(1);
    end
  end

  // A return with no send on a full counter is a protocol error; the counter saturates.
  always_comb begin
    cnt_d = cnt_q;
    ovf   = '0;
    for (int v = 0; v < VC_W; v++) begin
      if (gnt[v] && !i_credit_gnt[v]) begin
        cnt_d[v] = cnt_q[v] - CW'(1);
      end else if (!gnt[v] && i_credit_gnt[v]) begin
        if (cnt_q[v] == MAX_CREDIT) begin
          ovf[v] = 1'b1;
        end else begin
          cnt_d[v] = cnt_q[v] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {VC_W{MAX_CREDIT}};
      ptr_q    <= '0;
      data_q   <= '0;
      target_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      target_q <= target_d;
    end
  end

  assign o_d         = data_q;
  assign o_vc_target = target_q;

`ifndef SYNTHESIS
  creditOverflow: assert property (@(posedge clk) disable iff (!rst_n) ovf == '0);
`endif

endmodule

// File: tb/tb_credit_bp_tx.sv
// Directed bench for credit_bp_tx: reset, credit exhaustion, starvation,
// send+return balance, round-robin and asynchronous mid-stream reset.
module tb_credit_bp_tx;

  localparam int A_W = 4;
  localparam int D_W = 8;
  localparam int VC_W = 2;
  localparam int DEPTH = 4;
  localparam int FW = A_W + D_W + 1;

  logic                       clk;
  logic                       rst_n;
  logic [VC_W-1:0]            i_v;
  logic [VC_W-1:0][FW-1:0]    i_d;
  logic [VC_W-1:0]            o_b;
  logic [FW-1:0]              o_d;
  logic [VC_W-1:0]            o_vc_target;
  logic [VC_W-1:0]            i_credit_gnt;

  int nChecks;
  int nFails;

  credit_bp_tx #(
    .A_W(A_W), .D_W(D_W), .VC_W(VC_W), .VC_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_v(i_v),
    .i_d(i_d),
    .o_b(o_b),
    .o_d(o_d),
    .o_vc_target(o_vc_target),
    .i_credit_gnt(i_credit_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
      else begin
        nFails++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [VC_W-1:0] v, input logic [VC_W-1:0] ret);
    i_v          = v;
    i_credit_gnt = ret;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [FW-1:0] lastData;
    nChecks = 0;
    nFails  = 0;
    rst_n   = 1'b0;
    i_d     = '0;
    applyStimulus(2'b00, 2'b00);

    // Reset state
    #12;
    checkOutput("reset_target", 32'(o_vc_target), 32'h0);
    checkOutput("reset_data", 32'(o_d), 32'h0);
    checkOutput("reset_ob", 32'(o_b), 32'h3);
    tick();
    rst_n = 1'b1;

    // Credit exhaustion on VC0: three transfers, then blocked
    for (int k = 0; k < 5; k++) begin
      i_d[0] = 13'h1A00 + 13'(k);
      applyStimulus(2'b01, 2'b00);
      #1;
      checkOutput($sformatf("exh_ob_%0d", k), 32'(o_b), (k < 3) ? 32'h2 : 32'h3);
      tick();
      checkOutput($sformatf("exh_tgt_%0d", k), 32'(o_vc_target), (k < 3) ? 32'h1 : 32'h0);
      if (k < 3) checkOutput($sformatf("exh_data_%0d", k), 32'(o_d), 32'h1A00 + 32'(k));
    end
    checkOutput("exh_hold_data", 32'(o_d), 32'h1A02);

    // One credit returned: still blocked this cycle, one transfer the next
    i_d[0] = 13'h0A55;
    applyStimulus(2'b01, 2'b01);
    #1;
    checkOutput("ret_nobypass_ob", 32'(o_b), 32'h3);
    tick();
    checkOutput("ret_nobypass_tgt", 32'(o_vc_target), 32'h0);
    applyStimulus(2'b01, 2'b00);
    #1;
    checkOutput("ret_use_ob", 32'(o_b), 32'h2);
    tick();
    checkOutput("ret_use_tgt", 32'(o_vc_target), 32'h1);
    checkOutput("ret_use_data", 32'(o_d), 32'h0A55);

    // Starvation: VC0 empty, VC1 served every cycle (cnt1 3->1)
    for (int k = 0; k < 2; k++) begin
      i_d[1] = 13'h0B10 + 13'(k);
      applyStimulus(2'b11, 2'b00);
      #1;
      checkOutput($sformatf("starve_ob_%0d", k), 32'(o_b), 32'h1);
      tick();
      checkOutput($sformatf("starve_tgt_%0d", k), 32'(o_vc_target), 32'h2);
      checkOutput($sformatf("starve_data_%0d", k), 32'(o_d), 32'h0B10 + 32'(k));
    end
    // Credits back on both VCs while VC1 sends; VC1 stays at 1, VC0 becomes 1
    applyStimulus(2'b11, 2'b11);
    #1;
    checkOutput("starve_ret_ob", 32'(o_b), 32'h1);
    tick();
    checkOutput("starve_ret_tgt", 32'(o_vc_target), 32'h2);
    // Pointer now at VC0, so VC0 wins over eligible VC1
    i_d[0] = 13'h1C0C;
    applyStimulus(2'b11, 2'b00);
    #1;
    checkOutput("starve_win_ob", 32'(o_b), 32'h2);
    tick();
    checkOutput("starve_win_tgt", 32'(o_vc_target), 32'h1);
    checkOutput("starve_win_data", 32'(o_d), 32'h1C0C);

    // Send + return on VC1 at cnt=1 for 10 cycles
    for (int k = 0; k < 10; k++) begin
      i_d[1] = 13'h0D00 + 13'(k * 3);
      applyStimulus(2'b10, 2'b10);
      #1;
      checkOutput($sformatf("bal_ob_%0d", k), 32'(o_b), 32'h1);
      tick();
      checkOutput($sformatf("bal_tgt_%0d", k), 32'(o_vc_target), 32'h2);
      checkOutput($sformatf("bal_data_%0d", k), 32'(o_d), 32'h0D00 + 32'(k * 3));
    end
    // The single remaining credit allows exactly one more flit
    i_d[1] = 13'h1EEE;
    applyStimulus(2'b10, 2'b00);
    tick();
    checkOutput("bal_last_tgt", 32'(o_vc_target), 32'h2);
    checkOutput("bal_last_data", 32'(o_d), 32'h1EEE);
    #1;
    checkOutput("bal_empty_ob", 32'(o_b), 32'h3);
    tick();
    checkOutput("bal_empty_tgt", 32'(o_vc_target), 32'h0);
    lastData = 13'h1EEE;
    checkOutput("bal_hold_data", 32'(o_d), 32'(lastData));

    // Refill both VCs from 0 to 3
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b00, 2'b11);
      tick();
    end

    // Round-robin with both valid: 01,10,01,10 with no gaps
    for (int k = 0; k < 4; k++) begin
      i_d[0] = 13'h0100 + 13'(k);
      i_d[1] = 13'h0200 + 13'(k);
      applyStimulus(2'b11, 2'b00);
      #1;
      checkOutput($sformatf("rr_ob_%0d", k), 32'(o_b), (k % 2 == 0) ? 32'h2 : 32'h1);
      tick();
      checkOutput($sformatf("rr_tgt_%0d", k), 32'(o_vc_target), (k % 2 == 0) ? 32'h1 : 32'h2);
      checkOutput($sformatf("rr_data_%0d", k), 32'(o_d), (k % 2 == 0) ? 32'h0100 + 32'(k) : 32'h0200 + 32'(k));
    end

    // Drain VC0 to 0 (cnt0 1->0), then reset mid-stream
    i_d[0] = 13'h0777;
    applyStimulus(2'b01, 2'b00);
    tick();
    checkOutput("pre_rst_tgt", 32'(o_vc_target), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_tgt", 32'(o_vc_target), 32'h0);
    checkOutput("async_rst_data", 32'(o_d), 32'h0);
    applyStimulus(2'b00, 2'b00);
    #1;
    checkOutput("async_rst_ob", 32'(o_b), 32'h3);
    tick();
    rst_n = 1'b1;

    // Both counters back at 3: six alternating transfers, then idle
    for (int k = 0; k < 7; k++) begin
      i_d[0] = 13'h0300 + 13'(k);
      i_d[1] = 13'h0400 + 13'(k);
      applyStimulus(2'b11, 2'b00);
      tick();
      if (k < 6) begin
        checkOutput($sformatf("post_rst_tgt_%0d", k), 32'(o_vc_target), (k % 2 == 0) ? 32'h1 : 32'h2);
      end else begin
        checkOutput("post_rst_idle_tgt", 32'(o_vc_target), 32'h0);
      end
    end
    #1;
    checkOutput("post_rst_empty_ob", 32'(o_b), 32'h3);

    applyStimulus(2'b00, 2'b00);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
